mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Serialises 32-bit fetches and 1/2/4-byte loads/stores into byte transfers.
- Delivers each fetched word with a one-cycle done pulse, which feeds IF's if_flag/if_inst path into the IF/ID register.
- Raises per-stage stall requests to the stall controller and drops an in-flight fetch when EX signals a taken branch.

Parameters:
ADDR_WIDTH, 32, width of all byte addresses
DATA_WIDTH, 32, width of instruction and load/store data words

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
if_req  in  1  fetch request, held until if_done or flush
if_addr  in  ADDR_WIDTH  fetch byte address
if_done  out  1  one-cycle pulse, if_inst valid
if_inst  out  DATA_WIDTH  assembled instruction, little-endian
mem_req  in  1  load/store request, held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_WIDTH  load/store byte address
mem_len  in  2  bytes minus 1: 0 = byte, 1 = half, 3 = word (2 is illegal, treated as 3)
mem_wdata  in  DATA_WIDTH  store data, byte 0 = bits 7:0
mem_done  out  1  one-cycle pulse, access complete
mem_rdata  out  DATA_WIDTH  load data, zero-filled above mem_len
branch_flush  in  1  taken branch from EX
stall_req_if  out  1  fetch outstanding
stall_req_mem  out  1  load/store outstanding
ram_addr  out  ADDR_WIDTH  RAM byte address
ram_we  out  1  RAM write strobe
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid one cycle after its address

Behaviour:
- Reset (rst=0 at an edge): state IDLE; counter 0. All outputs are 0, including if_done, mem_done, ram_we, stall_req_*, ram_addr, ram_dout, if_inst and mem_rdata.
- Reset during any busy state aborts the access the same edge. No done pulse is issued and ram_we is 0 next cycle.
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration:
  - If mem_req=1, go to MEM_WR (mem_we=1) or MEM_RD (mem_we=0).
  - Else if if_req=1 and branch_flush=0, go to IF_RD.
  - mem_req always has priority.
  - Base address and length are latched on entry; the counter is cleared.
- Address and data path:
  - ram_addr = latched base + counter (wraps modulo 2^ADDR_WIDTH).
  - ram_addr holds its last value in IDLE and DONE.
- Read (IF_RD or MEM_RD, N = len+1 bytes, len = 3 for IF):
  - Busy cycles c0..cN: address base+k is driven in cycle ck for k<N; no address is driven in cN.
  - ram_din in cycle c(k+1) is written into byte k of the assembly register.
  - After cN, go to DONE.
- Write (MEM_WR):
  - In cycles c0..c(N-1), ram_we=1, ram_addr=base+k, ram_dout=mem_wdata byte k.
  - After c(N-1), go to DONE.
  - ram_we is 0 in every other state.
- DONE (one cycle):
  - Pulse the done signal of the owning requester.
  - Present the assembled data on if_inst or mem_rdata; data stays held until the next completion of the same type.
  - Then go to IDLE.
  - The requester drops req at the edge ending DONE.
- Latency from the IDLE cycle where the request is accepted to the done pulse:
  - word read or fetch: 6 cycles
  - byte read: 3 cycles
  - word write: 5 cycles
  - byte write: 2 cycles
- Flush:
  - branch_flush=1 in IF_RD aborts the fetch: go to IDLE, no if_done.
  - branch_flush=1 in a DONE owned by IF suppresses if_done.
  - branch_flush has no effect on MEM_RD or MEM_WR, because the MEM instruction is older than the branch.
- Stall requests:
  - stall_req_if = if_req & ~if_done & ~branch_flush.
  - stall_req_mem = mem_req & ~mem_done.
  - Both are combinational.

Optional Feature:
IF_PREEMPT_EN:
- Defined: mem_req=1 during IF_RD aborts the fetch that cycle, and the next state is MEM_RD or MEM_WR. The fetch restarts from byte 0 once the arbiter returns to IDLE and if_req is still high.
- Undefined: a fetch in progress always completes before a pending mem_req is served.

Test Plan:
- Word fetch: if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_addr 0x100..0x103 in consecutive cycles; if_done pulse 6 cycles after acceptance; if_inst=0x00100513.
- Byte store: mem_req=1, mem_we=1, mem_len=0, mem_addr=0x30004, mem_wdata=0xAABBCC41 -> single cycle with ram_we=1, ram_addr=0x30004, ram_dout=0x41; mem_done 2 cycles after acceptance; no other ram_we.
- Simultaneous requests in IDLE: if_req=1 and mem_req=1 (halfword load, addr 0x200 holding 0x34,0x12) -> load served first, mem_rdata=0x00001234; fetch starts in the IDLE cycle after DONE; stall_req_if stays 1 throughout.
- Flush: branch_flush=1 during IF_RD counter=2 -> no if_done; IDLE next cycle; a new if_req at 0x40 completes normally.
- Reset mid-write: rst=0 at word store counter=1 -> ram_we=0 next cycle; no mem_done; all outputs 0.
- Wrap: word fetch at 0xFFFFFFFE -> ram_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. With IF_PREEMPT_EN, mem_req mid-fetch -> MEM state next cycle and the fetch is reissued from byte 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM port shared by IF fetches and MEM loads/stores.
// Define IF_PREEMPT_EN to let a pending load/store abort an in-flight fetch.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_len,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_done,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  branch_flush,
  output logic                  stall_req_if,
  output logic                  stall_req_mem,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  typedef enum logic [2:0] {
    IDLE, IF_RD, MEM_RD, MEM_WR, DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_IF, OWN_LD, OWN_ST
  } own_t;

  state_t                state, state_n;
  own_t                  own;
  logic [2:0]            cnt, cnt_n;
  logic [1:0]            len;
  logic [1:0]            bidx;
  logic [ADDR_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] wdata_q, asm_q;
  logic [DATA_WIDTH-1:0] inst_q, rdata_q;
  logic                  acc_if, acc_mem;
  logic                  rd_st, rd_end, wr_end;

  assign rd_st  = (state == IF_RD) || (state == MEM_RD);
  assign rd_end = cnt == ({1'b0, len} + 3'd1);
  assign wr_end = cnt == {1'b0, len};
  assign bidx   = cnt[1:0] - 2'd1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_if  = 1'b0;
    acc_mem = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req)
          acc_mem = 1'b1;
        else if (if_req && !branch_flush)
          acc_if = 1'b1;
      end
      IF_RD: begin
`ifdef IF_PREEMPT_EN
        if (mem_req)
          acc_mem = 1'b1;
        else
`endif
        if (branch_flush)
          state_n = IDLE;
        else if (rd_end)
          state_n = DONE;
        else
          cnt_n = cnt + 3'd1;
      end
      MEM_RD: begin
        if (rd_end)
          state_n = DONE;
        else
          cnt_n = cnt + 3'd1;
      end
      MEM_WR: begin
        if (wr_end)
          state_n = DONE;
        else
          cnt_n = cnt + 3'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (acc_mem) begin
      state_n = mem_we ? MEM_WR : MEM_RD;
      cnt_n   = 3'd0;
    end else if (acc_if) begin
      state_n = IF_RD;
      cnt_n   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      own      <= OWN_IF;
      cnt      <= 3'd0;
      len      <= 2'd0;
      base     <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      inst_q   <= '0;
      rdata_q  <= '0;
      ram_addr <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // RAM answers one cycle late, so cycle k holds byte k-1
      if (rd_st && cnt != 3'd0)
        asm_q[{bidx, 3'b000} +: 8] <= ram_din;
      if ((rd_st || state == MEM_WR) &&
          state_n == state &&
          cnt_n <= {1'b0, len})
        ram_addr <= base + ADDR_WIDTH'(cnt_n);
      if (acc_mem) begin
        base     <= mem_addr;
        len      <= (mem_len == 2'd2) ? 2'd3 : mem_len;
        own      <= mem_we ? OWN_ST : OWN_LD;
        wdata_q  <= mem_wdata;
        asm_q    <= '0;
        ram_addr <= mem_addr;
      end else if (acc_if) begin
        base     <= if_addr;
        len      <= 2'd3;
        own      <= OWN_IF;
        asm_q    <= '0;
        ram_addr <= if_addr;
      end
      if (if_done)
        inst_q <= asm_q;
      if (mem_done && own == OWN_LD)
        rdata_q <= asm_q;
    end
  end

  assign ram_we   = state == MEM_WR;
  assign ram_dout = ram_we ?
                    wdata_q[{cnt[1:0], 3'b000} +: 8] :
                    8'h00;

  assign if_done  = (state == DONE) &&
                    (own == OWN_IF) &&
                    !branch_flush;
  assign mem_done = (state == DONE) &&
                    (own != OWN_IF);

  assign if_inst   = if_done ? asm_q : inst_q;
  assign mem_rdata = (mem_done && own == OWN_LD) ?
                     asm_q : rdata_q;

  assign stall_req_if  = if_req & ~if_done & ~branch_flush;
  assign stall_req_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-scheduled transaction model, RAM model,
// directed plan cases plus randomized traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        branch_flush = 1'b0;
  logic        stall_req_if;
  logic        stall_req_mem;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .branch_flush(branch_flush),
    .stall_req_if(stall_req_if),
    .stall_req_mem(stall_req_mem),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_dout(ram_dout), .ram_din(ram_din)
  );

  logic [7:0] pre [logic [31:0]];
  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] base_rd(input logic [31:0] a);
    return pre.exists(a) ? pre[a] : fill(a);
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : base_rd(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : base_rd(a);
  endfunction

  always @(posedge clk) begin
    if (ram_we === 1'b1) ram[ram_addr] = ram_dout;
    ram_din <= ram_rd(ram_addr);
  end

  bit          e_we   [int];
  logic [31:0] e_addr [int];
  logic [7:0]  e_dout [int];
  bit          e_ifd  [int];
  logic [31:0] e_inst [int];
  bit          e_memd [int];
  logic [31:0] e_rd   [int];
  bit          e_rst  [int];
  logic [31:0] lit    [int];

  int total = 0;
  int bad = 0;
  logic [31:0] li = '0;
  logic [31:0] lr = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp, input int c);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int c;
    bit xi, xm;
    if (cyc >= 1) begin
      c = cyc;
      if (e_rst.exists(c)) begin
        li = '0;
        lr = '0;
      end
      xi = e_ifd.exists(c);
      xm = e_memd.exists(c);
      if (xi) li = e_inst[c];
      if (xm && e_rd.exists(c)) lr = e_rd[c];
      chk("ram_we", 32'(ram_we), 32'(e_we.exists(c)), c);
      if (e_addr.exists(c))
        chk("ram_addr", ram_addr, e_addr[c], c);
      if (e_we.exists(c))
        chk("ram_dout", 32'(ram_dout), 32'(e_dout[c]), c);
      chk("if_done", 32'(if_done), 32'(xi), c);
      chk("if_inst", if_inst, li, c);
      chk("mem_done", 32'(mem_done), 32'(xm), c);
      chk("mem_rdata", mem_rdata, lr, c);
      chk("stall_if", 32'(stall_req_if),
          32'(if_req & ~xi & ~branch_flush), c);
      chk("stall_mem", 32'(stall_req_mem),
          32'(mem_req & ~xm), c);
      for (int s = 0; s < 7; s++) begin
        if (lit.exists(c * 8 + s)) begin
          case (s)
            0: chk("lit_if_inst", if_inst, lit[c*8+s], c);
            1: chk("lit_mem_rdata", mem_rdata, lit[c*8+s], c);
            2: chk("lit_ram_addr", ram_addr, lit[c*8+s], c);
            3: chk("lit_ram_we", 32'(ram_we), lit[c*8+s], c);
            4: chk("lit_if_done", 32'(if_done), lit[c*8+s], c);
            5: chk("lit_mem_done", 32'(mem_done), lit[c*8+s], c);
            default: chk("lit_ram_dout", 32'(ram_dout), lit[c*8+s], c);
          endcase
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setlit(input int c, input int s, input logic [31:0] v);
    lit[c * 8 + s] = v;
  endtask

  // kind: 0 fetch, 1 load, 2 store; a = accepting cycle
  task automatic sched(input int kind, input int a,
                       input logic [31:0] addr, input logic [1:0] len,
                       input logic [31:0] wd, output int d);
    int n;
    logic [31:0] v;
    n = (kind == 0 || len == 2'd2) ? 4 : int'(len) + 1;
    v = '0;
    for (int k = 0; k < n; k++) begin
      e_addr[a + 1 + k] = addr + 32'(k);
      if (kind == 2) begin
        e_we[a + 1 + k]   = 1'b1;
        e_dout[a + 1 + k] = wd[8*k +: 8];
        mdl[addr + 32'(k)] = wd[8*k +: 8];
      end else begin
        v[8*k +: 8] = mdl_rd(addr + 32'(k));
      end
    end
    if (kind == 2) begin
      d = a + n + 1;
      e_memd[d] = 1'b1;
    end else begin
      d = a + n + 2;
      if (kind == 0) begin
        e_ifd[d]  = 1'b1;
        e_inst[d] = v;
      end else begin
        e_memd[d] = 1'b1;
        e_rd[d]   = v;
      end
    end
  endtask

  task automatic start(input int kind, input logic [31:0] addr,
                       input logic [1:0] len, input logic [31:0] wd);
    if (kind == 0) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_req   = 1'b1;
      mem_we    = (kind == 2);
      mem_addr  = addr;
      mem_len   = len;
      mem_wdata = wd;
    end
  endtask

  task automatic drop(input int kind);
    if (kind == 0) if_req = 1'b0;
    else mem_req = 1'b0;
  endtask

  task automatic xact(input int kind, input logic [31:0] addr,
                      input logic [1:0] len, input logic [31:0] wd);
    int d;
    start(kind, addr, len, wd);
    sched(kind, cyc, addr, len, wd, d);
    step(d - cyc);
    step(1);
    drop(kind);
  endtask

  initial begin
    int a, d, kind;
    logic [31:0] ad, wd, fa;
    logic [1:0] ln;

    pre[32'h100] = 8'h13;
    pre[32'h101] = 8'h05;
    pre[32'h102] = 8'h10;
    pre[32'h103] = 8'h00;
    pre[32'h200] = 8'h34;
    pre[32'h201] = 8'h12;

    setlit(2, 0, 32'h0);
    setlit(2, 1, 32'h0);
    setlit(2, 2, 32'h0);
    setlit(2, 3, 32'h0);
    setlit(2, 6, 32'h0);
    step(3);
    rst = 1'b1;
    step(1);

    // word fetch
    a = cyc;
    setlit(a + 1, 2, 32'h100);
    setlit(a + 4, 2, 32'h103);
    setlit(a + 6, 4, 32'h1);
    setlit(a + 6, 0, 32'h00100513);
    xact(0, 32'h100, 2'd3, 32'h0);

    // byte store
    a = cyc;
    setlit(a + 1, 3, 32'h1);
    setlit(a + 1, 2, 32'h30004);
    setlit(a + 1, 6, 32'h41);
    setlit(a + 2, 5, 32'h1);
    setlit(a + 2, 3, 32'h0);
    xact(2, 32'h30004, 2'd0, 32'hAABBCC41);

    // simultaneous: halfword load wins, fetch follows
    a = cyc;
    start(0, 32'h100, 2'd3, 32'h0);
    start(1, 32'h200, 2'd1, 32'h0);
    sched(1, a, 32'h200, 2'd1, 32'h0, d);
    setlit(a + 4, 5, 32'h1);
    setlit(a + 4, 1, 32'h00001234);
    setlit(a + 11, 4, 32'h1);
    step(d - cyc);
    step(1);
    drop(1);
    sched(0, cyc, 32'h100, 2'd3, 32'h0, d);
    step(d - cyc);
    step(1);
    drop(0);

    // flush in IF_RD at counter 2, then a fresh fetch at 0x40
    a = cyc;
    start(0, 32'h80, 2'd3, 32'h0);
    for (int k = 0; k < 3; k++) e_addr[a + 1 + k] = 32'h80 + 32'(k);
    step(3);
    branch_flush = 1'b1;
    step(1);
    branch_flush = 1'b0;
    if_addr = 32'h40;
    sched(0, cyc, 32'h40, 2'd3, 32'h0, d);
    setlit(a + 10, 4, 32'h1);
    step(d - cyc);
    step(1);
    drop(0);

    // reset at counter 1 of a word store
    a = cyc;
    start(2, 32'h500, 2'd3, 32'h11223344);
    for (int k = 0; k < 2; k++) begin
      e_we[a + 1 + k]   = 1'b1;
      e_addr[a + 1 + k] = 32'h500 + 32'(k);
      e_dout[a + 1 + k] = (k == 0) ? 8'h44 : 8'h33;
      mdl[32'h500 + 32'(k)] = (k == 0) ? 8'h44 : 8'h33;
    end
    step(2);
    rst = 1'b0;
    mem_req = 1'b0;
    e_rst[a + 3] = 1'b1;
    setlit(a + 3, 3, 32'h0);
    setlit(a + 3, 2, 32'h0);
    setlit(a + 3, 5, 32'h0);
    setlit(a + 3, 0, 32'h0);
    setlit(a + 3, 1, 32'h0);
    step(1);
    rst = 1'b1;
    step(1);
    xact(1, 32'h500, 2'd3, 32'h0);

    // fetch wrapping the address space
    a = cyc;
    setlit(a + 1, 2, 32'hFFFFFFFE);
    setlit(a + 2, 2, 32'hFFFFFFFF);
    setlit(a + 3, 2, 32'h0);
    setlit(a + 4, 2, 32'h1);
    xact(0, 32'hFFFFFFFE, 2'd3, 32'h0);

    // flush during an IF-owned DONE
    a = cyc;
    start(0, 32'h104, 2'd3, 32'h0);
    sched(0, a, 32'h104, 2'd3, 32'h0, d);
    e_ifd.delete(d);
    e_inst.delete(d);
    setlit(a + 6, 4, 32'h0);
    step(d - cyc);
    branch_flush = 1'b1;
    step(1);
    branch_flush = 1'b0;
    if_req = 1'b0;

`ifdef IF_PREEMPT_EN
    // load preempts a fetch in its second byte cycle
    a = cyc;
    start(0, 32'h100, 2'd3, 32'h0);
    e_addr[a + 1] = 32'h100;
    e_addr[a + 2] = 32'h101;
    step(2);
    start(1, 32'h200, 2'd0, 32'h0);
    sched(1, cyc, 32'h200, 2'd0, 32'h0, d);
    setlit(a + 5, 1, 32'h34);
    step(d - cyc);
    step(1);
    drop(1);
    sched(0, cyc, 32'h100, 2'd3, 32'h0, d);
    setlit(a + 12, 0, 32'h00100513);
    step(d - cyc);
    step(1);
    drop(0);
`endif

    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 2));
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0)
        ad = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      else
        ad = $urandom;
      ln = 2'($urandom);
      wd = $urandom;
      if (kind != 0 && $urandom_range(0, 3) == 0) begin
        fa = $urandom;
        start(0, fa, 2'd3, 32'h0);
        start(kind, ad, ln, wd);
        sched(kind, cyc, ad, ln, wd, d);
        step(d - cyc);
        step(1);
        drop(kind);
        sched(0, cyc, fa, 2'd3, 32'h0, d);
        step(d - cyc);
        step(1);
        drop(0);
      end else begin
        if (kind == 0 && $urandom_range(0, 3) == 0) begin
          start(0, ad, 2'd3, 32'h0);
          branch_flush = 1'b1;
          step(1);
          branch_flush = 1'b0;
        end
        xact(kind, ad, ln, wd);
      end
    end

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
